// File: rtl/hilo_fwd_unit.sv
// HI/LO architectural registers with per-half forwarding, writeback bypass and
// a multi-cycle mul/div tracker (IDLE/BUSY) with timeout and EX stall request.
module hilo_fwd_unit #(
  parameter int W       = 32,
  parameter int NFWD    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NFWD-1:0] fwd_we_hi,
  input  logic [NFWD-1:0] fwd_we_lo,
  input  logic [NFWD*W-1:0] fwd_hi,
  input  logic [NFWD*W-1:0] fwd_lo,
  input  logic            wb_we_hi,
  input  logic            wb_we_lo,
  input  logic [W-1:0]    wb_hi,
  input  logic [W-1:0]    wb_lo,
  input  logic            md_start,
  input  logic            md_cancel,
  input  logic            md_res_valid,
  input  logic [W-1:0]    md_res_hi,
  input  logic [W-1:0]    md_res_lo,
  input  logic            rd_req,
  output logic [W-1:0]    hi,
  output logic [W-1:0]    lo,
  output logic [W-1:0]    hi_q,
  output logic [W-1:0]    lo_q,
  output logic            stall_req,
  output logic            md_busy,
  output logic            md_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [W-1:0]  r_hi_q;
  logic [W-1:0]  r_lo_q;
  logic          w_md_write;
  logic [W-1:0]  w_hi;
  logic [W-1:0]  w_lo;
  logic          w_hi_hit;
  logic          w_lo_hit;

  // Cancel beats a same-cycle result; results outside BUSY are dropped.
  assign w_md_write = (r_state == BUSY) && md_res_valid && !md_cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_hi_q  <= '0;
      r_lo_q  <= '0;
    end else begin
      if (w_md_write) begin
        r_hi_q <= md_res_hi;
        r_lo_q <= md_res_lo;
      end else begin
        if (wb_we_hi) r_hi_q <= wb_hi;
        if (wb_we_lo) r_lo_q <= wb_lo;
      end
      case (r_state)
        IDLE: begin
          if (md_start && !md_cancel) begin
            r_state <= BUSY;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (md_cancel || md_res_valid) begin
            r_state <= IDLE;
          end else if (md_start) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Youngest pending stage wins, then the writeback bypass, then the register.
  always_comb begin
    w_hi     = wb_we_hi ? wb_hi : r_hi_q;
    w_lo     = wb_we_lo ? wb_lo : r_lo_q;
    w_hi_hit = 1'b0;
    w_lo_hit = 1'b0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!w_hi_hit && fwd_we_hi[i]) begin
        w_hi     = fwd_hi[i*W +: W];
        w_hi_hit = 1'b1;
      end
      if (!w_lo_hit && fwd_we_lo[i]) begin
        w_lo     = fwd_lo[i*W +: W];
        w_lo_hit = 1'b1;
      end
    end
  end

  assign md_busy   = (r_state == BUSY);
  assign hi        = rst ? '0 : w_hi;
  assign lo        = rst ? '0 : w_lo;
  assign stall_req = !rst && rd_req && (md_busy || md_start);
  assign hi_q      = r_hi_q;
  assign lo_q      = r_lo_q;
  assign md_err    = r_err;

endmodule
